// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions and the transmitter state encoding.
package uart_pkg;

  localparam int unsigned DIV_W = 16;

  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_DIV  = 2'd1;
  localparam logic [1:0] UART_CTRL = 2'd2;

  localparam int unsigned ST_TX_EMPTY  = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_BUSY      = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // A divider of zero would stall the bit timer forever, so it becomes one.
  function automatic logic [DIV_W-1:0] div_sanitize(input logic [DIV_W-1:0] v);
    return (v == '0) ? DIV_W'(1) : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// A push is refused while full, even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/uart_tx_mmap.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to DATA are queued in a FIFO
// and shifted out LSB first on tx at a programmable clocks-per-bit rate.
module uart_tx_mmap
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        re,
  output logic [31:0] rd,
  input  logic        we,
  input  logic [31:0] wd,
  output logic        tx,
  output logic        tx_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_t      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_lat_q, div_lat_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  logic             wr_data, wr_div, wr_ctrl;
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      status;
  logic             unused_bits;

  assign wr_data = we && (addr[1:0] == UART_DATA);
  assign wr_div  = we && (addr[1:0] == UART_DIV);
  assign wr_ctrl = we && (addr[1:0] == UART_CTRL);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (wr_data),
    .pop  (fifo_pop),
    .din  (wd[7:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Register file: divider and sticky overflow flag.
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_div) begin
      div_d = div_sanitize(wd[15:0]);
    end
    if (wr_data && fifo_full) begin
      ovf_d = 1'b1;
    end
    if (wr_ctrl && wd[0]) begin
      ovf_d = 1'b0;
    end
  end

  // Frame sequencer; tx_d is the line level for the current state, so tx
  // trails the state by one cycle uniformly across every bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    tx_d      = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          div_lat_d = div_q;
          cnt_d     = div_q - DIV_W'(1);
          state_d   = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (cnt_q == '0) begin
          cnt_d     = div_lat_q - DIV_W'(1);
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (cnt_q == '0) begin
          cnt_d   = div_lat_q - DIV_W'(1);
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_dout;
            div_lat_d = div_q;
            cnt_d     = div_q - DIV_W'(1);
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_lat_q <= DEFAULT_DIV;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      div_q     <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx     = tx_q;
  assign tx_irq = fifo_empty && (state_q == IDLE);

  // Read path is combinational from the address and current state.
  always_comb begin
    status                      = '0;
    status[ST_TX_EMPTY]         = tx_irq;
    status[ST_FULL]             = fifo_full;
    status[ST_BUSY]             = (state_q != IDLE);
    status[ST_OVF]              = ovf_q;
    status[ST_COUNT_LSB +: 8]   = 8'(fifo_count);
    rd = '0;
    if (re) begin
      case (addr[1:0])
        UART_DATA: rd = status;
        UART_DIV:  rd = {16'h0, div_q};
        default:   rd = '0;
      endcase
    end
  end

  assign unused_bits = ^{addr[29:2], wd[31:16]};

endmodule

// File: tb/tb_uart_tx_mmap.sv
// Self-checking bench for uart_tx_mmap: a frame-timing reference model checked
// every cycle, plus directed frames decoded from the tx pin.
module tb_uart_tx_mmap;

  localparam int unsigned DEPTH   = 4;
  localparam logic [15:0] DEF_DIV = 16'd868;

  logic        clk, reset, re, we, tx, tx_irq;
  logic [29:0] addr;
  logic [31:0] rd, wd;

  uart_tx_mmap #(
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(DEF_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .re    (re),
    .rd    (rd),
    .we    (we),
    .wd    (wd),
    .tx    (tx),
    .tx_irq(tx_irq)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a byte queue plus the start edge, divider and byte of the
  // frame on the wire. Line level is pure arithmetic on elapsed cycles.
  logic [7:0]  m_q[$];
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_ovf   = 1'b0;
  logic [15:0] m_div   = DEF_DIV;
  int          m_fstart, m_fdiv;
  logic [7:0]  m_fbyte;
  logic        m_exp_tx = 1'b1;
  int          m_cyc = 0;
  time         t_write;

  logic [7:0]  b0, b1;
  time         ts0, ts1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time exceeded, want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s     = '0;
    s[0]  = (m_q.size() == 0) && !m_busy;
    s[1]  = (m_q.size() == int'(DEPTH));
    s[2]  = m_busy;
    s[3]  = m_ovf;
    s[15:8] = 8'(m_q.size());
    return s;
  endfunction

  task automatic model_step();
    int  k;
    bit  full_pre, empty_pre;
    m_cyc++;
    if (!reset) begin
      m_q.delete();
      m_busy   = 1'b0;
      m_ovf    = 1'b0;
      m_div    = DEF_DIV;
      m_exp_tx = 1'b1;
      m_valid  = 1'b1;
      return;
    end
    if (!m_valid) return;
    // Line level after this edge reflects the frame position before it.
    if (m_busy) begin
      k = (m_cyc - 1 - m_fstart) / m_fdiv;
      if (k == 0)      m_exp_tx = 1'b0;
      else if (k == 9) m_exp_tx = 1'b1;
      else             m_exp_tx = m_fbyte[k-1];
    end else begin
      m_exp_tx = 1'b1;
    end
    full_pre  = (m_q.size() == int'(DEPTH));
    empty_pre = (m_q.size() == 0);
    if (m_busy && (m_cyc == m_fstart + 10 * m_fdiv)) m_busy = 1'b0;
    if (!m_busy && !empty_pre) begin
      m_fbyte  = m_q.pop_front();
      m_fdiv   = int'(m_div);
      m_fstart = m_cyc;
      m_busy   = 1'b1;
    end
    if (we && addr[1:0] == 2'd0) begin
      if (!full_pre) m_q.push_back(wd[7:0]);
      else           m_ovf = 1'b1;
    end
    if (we && addr[1:0] == 2'd1) m_div = (wd[15:0] == 16'h0) ? 16'd1 : wd[15:0];
    if (we && addr[1:0] == 2'd2 && wd[0]) m_ovf = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (m_valid) begin
      check("tx", 32'(tx), 32'(m_exp_tx));
      e = m_status();
      check("tx_irq", 32'(tx_irq), 32'(e[0]));
      if (!re)                    e = '0;
      else if (addr[1:0] == 2'd1) e = {16'h0, m_div};
      else if (addr[1:0] != 2'd0) e = '0;
      check("rd", rd, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = {28'($urandom), a};
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    t_write = $time;
    #1;
    we = 1'b0;
    wd = $urandom;
  endtask

  task automatic check_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    addr = {28'($urandom), a};
    re   = 1'b1;
    @(negedge clk);
    check(name, rd, exp);
    tick();
    re = 1'b0;
  endtask

  // Decode one frame from the pin, sampling mid-bit.
  task automatic capture(input int div, output logic [7:0] b, output time ts);
    int n;
    n  = 0;
    b  = '0;
    ts = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: tx=%b want start bit 0", tx);
      return;
    end
    ts = $time;
    repeat (div / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (div) @(negedge clk);
      b[k] = tx;
    end
    repeat (div) @(negedge clk);
    check("stop_bit", 32'(tx), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (tx_irq !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    check("drain_irq", 32'(tx_irq), 32'd1);
  endtask

  initial begin
    int lows;
    we = 1'b0; re = 1'b0; addr = '0; wd = '0; reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    check_rd(2'd0, 32'h0000_0001, "idle_status");
    check_rd(2'd3, 32'h0, "idle_reg3");
    addr = '0;
    @(negedge clk);
    check("re_low", rd, 32'h0);
    tick();
    check_rd(2'd1, {16'h0, DEF_DIV}, "div_reset");

    // 0x55 at four cycles per bit, with start latency and irq timing.
    bus_write(2'd1, 32'd4);
    fork
      begin
        capture(4, b0, ts0);
        check("t1_byte", 32'(b0), 32'h55);
        check("t1_latency", 32'(ts0 - t_write), 32'd25);
        check("t1_irq_in_stop", 32'(tx_irq), 32'd0);
        @(negedge clk);
        check("t1_irq_after", 32'(tx_irq), 32'd1);
      end
      bus_write(2'd0, 32'h55);
    join
    tick();

    // Back-to-back frames with no idle gap.
    bus_write(2'd1, 32'd2);
    fork
      begin
        capture(2, b0, ts0);
        capture(2, b1, ts1);
        check("t2_byte_h", 32'(b0), 32'h68);
        check("t2_byte_i", 32'(b1), 32'h69);
        check("t2_gap", 32'(ts1 - ts0), 32'd200);
      end
      begin
        bus_write(2'd0, 32'h68);
        bus_write(2'd0, 32'h69);
      end
    join
    tick();

    // Overflow: one byte in flight, four queued, sixth dropped.
    bus_write(2'd1, 32'd100);
    for (int i = 0; i < 6; i++) bus_write(2'd0, 32'(8'hA0 + i));
    check_rd(2'd0, 32'h0000_040E, "ovf_status");
    bus_write(2'd2, 32'd1);
    check_rd(2'd0, 32'h0000_0406, "ovf_cleared");
    drain();

    // Divider change mid-frame applies from the next frame.
    bus_write(2'd1, 32'd5);
    fork
      begin
        capture(5, b0, ts0);
        capture(3, b1, ts1);
        check("t4_byte_a", 32'(b0), 32'hA3);
        check("t4_byte_b", 32'(b1), 32'h3C);
        check("t4_spacing", 32'(ts1 - ts0), 32'd500);
      end
      begin
        bus_write(2'd0, 32'hA3);
        repeat (20) tick();
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h3C);
      end
    join
    tick();
    check_rd(2'd1, 32'd3, "div_readback");
    bus_write(2'd1, 32'h0);
    check_rd(2'd1, 32'd1, "div_zero_is_one");
    drain();

    // Randomized traffic, including overflow bursts and divider changes.
    for (int it = 0; it < 600; it++) begin
      int op;
      op = $urandom_range(0, 11);
      if (op <= 4)      bus_write(2'd0, $urandom);
      else if (op == 5) bus_write(2'd1, ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 4)));
      else if (op == 6) bus_write(2'd2, $urandom);
      else if (op == 7) bus_write(2'd3, $urandom);
      else begin
        repeat ($urandom_range(1, 25)) begin
          re   = 1'($urandom);
          addr = 30'($urandom);
          tick();
        end
        re = 1'b0;
      end
    end
    drain();

    // Reset in the middle of the data bits truncates the frame.
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'h00);
    repeat (30) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    tick();
    check_rd(2'd0, 32'h0000_0001, "rst_status");
    check_rd(2'd1, {16'h0, DEF_DIV}, "rst_div");
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rst_quiet", 32'(lows), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
